// File: rtl/axi_ddr_pkg.sv
// Shared types and defaults for the DDR3 AXI read/write arbiter.
package axi_ddr_pkg;

  localparam int ADDR_W      = 30;
  localparam int BURST_LEN   = 16;
  localparam int DATA_BYTES  = 8;
  localparam int BURST_BYTES = BURST_LEN * DATA_BYTES;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  function automatic int burst_bytes(input int len, input int bytes);
    return len * bytes;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst start-address register: steps by one burst per advance, wraps to BEG
// when the next burst would run past END. Clear takes priority over advance.
module axi_burst_addr_gen #(
  parameter int                ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] BEG_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(1023),
  parameter int                STEP     = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic              i_clr,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   w_next;
  logic [ADDR_W:0]   w_last;
  logic              w_wrap;

  // One extra bit so a step past the top of the address space still compares correctly
  assign w_next = {1'b0, r_addr} + (ADDR_W+1)'(STEP);
  assign w_last = w_next + (ADDR_W+1)'(STEP - 1);
  assign w_wrap = w_last > {1'b0, END_ADDR};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= BEG_ADDR;
    end else if (i_clr) begin
      r_addr <= BEG_ADDR;
    end else if (i_adv) begin
      r_addr <= w_wrap ? BEG_ADDR : w_next[ADDR_W-1:0];
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/axi_rw_arbiter.sv
// Shares one DDR3 AXI port between the write and read masters, one burst per grant.
// Define AXI_RW_WR_PRIO_EN for fixed write priority; default is round-robin on ties.
module axi_rw_arbiter #(
  parameter int                ADDR_W        = 30,
  parameter int                CNT_W         = 10,
  parameter int                BURST_LEN     = 16,
  parameter int                DATA_BYTES    = 8,
  parameter int                RD_FIFO_DEPTH = 512,
  parameter logic [ADDR_W-1:0] WR_BEG_ADDR   = '0,
  parameter logic [ADDR_W-1:0] WR_END_ADDR   = ADDR_W'(1023),
  parameter logic [ADDR_W-1:0] RD_BEG_ADDR   = '0,
  parameter logic [ADDR_W-1:0] RD_END_ADDR   = ADDR_W'(1023)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_clr,
  input  logic              rd_mem_en,
  input  logic [CNT_W-1:0]  wr_fifo_cnt,
  input  logic [CNT_W-1:0]  rd_fifo_cnt,
  input  logic              wr_ready,
  input  logic              wr_done,
  input  logic              rd_ready,
  input  logic              rd_done,
  output logic              wr_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_len,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  output logic              busy
);
  import axi_ddr_pkg::*;

  // state      | meaning
  // ST_ARB     | evaluate eligibility, apply pending address clear, grant
  // ST_WR_REQ  | write granted, waiting for write master idle
  // ST_WR_WAIT | write burst in flight until wr_done
  // ST_RD_REQ  | read granted, waiting for read master idle
  // ST_RD_WAIT | read burst in flight until rd_done

  localparam int               BURST_STEP = burst_bytes(BURST_LEN, DATA_BYTES);
  localparam logic [CNT_W:0]   WR_THRESH  = (CNT_W+1)'(BURST_LEN);
  localparam logic [CNT_W:0]   RD_THRESH  = (CNT_W+1)'(RD_FIFO_DEPTH - BURST_LEN);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_wr_start, r_rd_start, r_clr_pend;
  logic   w_wr_start_nxt, w_rd_start_nxt, w_pend_nxt;
  logic   w_wr_adv, w_rd_adv, w_wr_clr, w_rd_clr;
  logic   w_wr_elig, w_rd_elig, w_clr_now, w_grant_vld;
  grant_e w_grant;

  assign w_wr_elig   = {1'b0, wr_fifo_cnt} >= WR_THRESH;
  assign w_rd_elig   = rd_mem_en && ({1'b0, rd_fifo_cnt} <= RD_THRESH);
  assign w_clr_now   = r_clr_pend | addr_clr;
  assign w_grant_vld = w_wr_elig | w_rd_elig;

`ifdef AXI_RW_WR_PRIO_EN
  always_comb begin
    w_grant = GNT_WR;
    if (!w_wr_elig) w_grant = GNT_RD;
  end
`else
  grant_e r_last_grant;

  always_comb begin
    w_grant = GNT_WR;
    if (w_wr_elig && w_rd_elig) w_grant = (r_last_grant == GNT_RD) ? GNT_WR : GNT_RD;
    else if (!w_wr_elig)        w_grant = GNT_RD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GNT_RD;
    end else if (r_state == ST_ARB && w_grant_vld) begin
      r_last_grant <= w_grant;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ARB;
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_start <= w_wr_start_nxt;
      r_rd_start <= w_rd_start_nxt;
      r_clr_pend <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_start_nxt = 1'b0;
    w_rd_start_nxt = 1'b0;
    w_wr_adv       = 1'b0;
    w_rd_adv       = 1'b0;
    w_wr_clr       = 1'b0;
    w_rd_clr       = 1'b0;
    w_pend_nxt     = w_clr_now;
    case (r_state)
      ST_ARB: begin
        w_wr_clr   = w_clr_now;
        w_rd_clr   = w_clr_now;
        w_pend_nxt = 1'b0;
        if (w_grant_vld) w_state_nxt = (w_grant == GNT_WR) ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        if (wr_ready) begin
          w_state_nxt    = ST_WR_WAIT;
          w_wr_start_nxt = 1'b1;
        end
      end
      // A pending clear overrides the advance for the finishing direction only;
      // it stays pending so the other address is cleared in the next ARB.
      ST_WR_WAIT: begin
        if (wr_done) begin
          w_state_nxt = ST_ARB;
          w_wr_adv    = 1'b1;
          w_wr_clr    = w_clr_now;
        end
      end
      ST_RD_REQ: begin
        if (rd_ready) begin
          w_state_nxt    = ST_RD_WAIT;
          w_rd_start_nxt = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (rd_done) begin
          w_state_nxt = ST_ARB;
          w_rd_adv    = 1'b1;
          w_rd_clr    = w_clr_now;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  axi_burst_addr_gen #(
    .ADDR_W  (ADDR_W),
    .BEG_ADDR(WR_BEG_ADDR),
    .END_ADDR(WR_END_ADDR),
    .STEP    (BURST_STEP)
  ) u_wr_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_wr_adv),
    .i_clr (w_wr_clr),
    .o_addr(wr_addr)
  );

  axi_burst_addr_gen #(
    .ADDR_W  (ADDR_W),
    .BEG_ADDR(RD_BEG_ADDR),
    .END_ADDR(RD_END_ADDR),
    .STEP    (BURST_STEP)
  ) u_rd_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_rd_adv),
    .i_clr (w_rd_clr),
    .o_addr(rd_addr)
  );

  assign wr_start = r_wr_start;
  assign rd_start = r_rd_start;
  assign wr_len   = 8'(BURST_LEN - 1);
  assign rd_len   = 8'(BURST_LEN - 1);
  assign busy     = (r_state != ST_ARB);

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed and randomized checks of axi_rw_arbiter against a burst-level model.
module tb_axi_rw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        addr_clr = 1'b0;
  logic        rd_mem_en = 1'b0;
  logic [9:0]  wr_fifo_cnt = '0;
  logic [9:0]  rd_fifo_cnt = '0;
  logic        wr_ready = 1'b1;
  logic        wr_done = 1'b0;
  logic        rd_ready = 1'b1;
  logic        rd_done = 1'b0;
  logic        wr_start, rd_start, busy;
  logic [29:0] wr_addr, rd_addr;
  logic [7:0]  wr_len, rd_len;

  always #5 clk = ~clk;

  axi_rw_arbiter dut (
    .clk(clk), .rst_n(rst_n), .addr_clr(addr_clr), .rd_mem_en(rd_mem_en),
    .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
    .wr_ready(wr_ready), .wr_done(wr_done), .rd_ready(rd_ready), .rd_done(rd_done),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .busy(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Burst-level reference: next expected start address per direction (0=WR, 1=RD)
  longint exp_addr[2];
  int     last_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint next_addr(input longint a);
    longint n;
    n = a + 16 * 8;
    if (n + 16 * 8 - 1 > 1023) return 0;
    return n;
  endfunction

  function automatic int pick_dir(input bit we, input bit re, input int last);
    if (we && re) return (last == 1) ? 0 : 1;
    if (we) return 0;
    if (re) return 1;
    return -1;
  endfunction

  task automatic wait_start(input int max_cyc, input int rdy_dly,
                            output int dir, output logic [29:0] a, output int cyc);
    dir = -1; a = '0; cyc = 0;
    wr_ready = (rdy_dly == 0);
    rd_ready = (rdy_dly == 0);
    for (int i = 0; i < max_cyc; i++) begin
      if (i == rdy_dly) begin wr_ready = 1'b1; rd_ready = 1'b1; end
      tick();
      if (wr_start) begin dir = 0; a = wr_addr; cyc = i + 1; break; end
      if (rd_start) begin dir = 1; a = rd_addr; cyc = i + 1; break; end
    end
    wr_ready = 1'b1;
    rd_ready = 1'b1;
  endtask

  task automatic do_burst(input string tag, input int exp_dir, input int rdy_dly,
                          input int dly, input bit clr, input bit stray, output int cyc);
    int dir;
    logic [29:0] a;
    wait_start(rdy_dly + 4, rdy_dly, dir, a, cyc);
    chk({tag, " grant"}, dir, exp_dir);
    if (dir != exp_dir || dir < 0) return;
    chk({tag, " start addr"}, a, 32'(exp_addr[dir]));
    chk({tag, " len"}, (dir == 0) ? wr_len : rd_len, 15);
    tick();
    chk({tag, " start width"}, {30'd0, wr_start, rd_start}, 0);
    for (int i = 0; i < dly; i++) tick();
    if (clr) begin addr_clr = 1'b1; tick(); addr_clr = 1'b0; end
    if (stray) begin
      if (dir == 0) rd_done = 1'b1; else wr_done = 1'b1;
      tick();
      rd_done = 1'b0; wr_done = 1'b0;
    end
    chk({tag, " addr stable"}, (dir == 0) ? wr_addr : rd_addr, a);
    chk({tag, " busy in burst"}, busy, 1);
    if (dir == 0) wr_done = 1'b1; else rd_done = 1'b1;
    tick();
    wr_done = 1'b0; rd_done = 1'b0;
    if (clr) begin exp_addr[0] = 0; exp_addr[1] = 0; end
    else exp_addr[dir] = next_addr(exp_addr[dir]);
    chk({tag, " addr after done"}, (dir == 0) ? wr_addr : rd_addr, 32'(exp_addr[dir]));
    chk({tag, " busy after done"}, busy, 0);
    last_dir = dir;
  endtask

  initial begin
    int cyc, dir, ed;
    logic [29:0] a;
    bit we, re, clr, stray;

    exp_addr[0] = 0; exp_addr[1] = 0; last_dir = 1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset wr_start", wr_start, 0);
    chk("reset rd_start", rd_start, 0);
    chk("reset busy", busy, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset rd_addr", rd_addr, 0);

    // Single write once 16 words are buffered
    rst_n = 1'b1;
    wr_fifo_cnt = 10'd16;
    do_burst("t1", 0, 0, 2, 0, 0, cyc);
    chk("t1 latency", cyc, 2);

    // Both eligible: alternating grants
    wr_fifo_cnt = 10'd100; rd_mem_en = 1'b1; rd_fifo_cnt = 10'd0;
    for (int i = 0; i < 4; i++) do_burst("t2 alt", (last_dir == 1) ? 0 : 1, 0, 3, 0, 0, cyc);

    // Writes only: walk through the wrap point
    rd_mem_en = 1'b0;
    for (int i = 0; i < 9; i++) do_burst("t3 wrap", 0, 0, 1, 0, 0, cyc);

    // Read free-space boundary; write one word short of a burst
    wr_fifo_cnt = 10'd15; rd_mem_en = 1'b1; rd_fifo_cnt = 10'd497;
    wait_start(12, 0, dir, a, cyc);
    chk("t4 no start at 497", dir, -1);
    chk("t4 idle busy", busy, 0);
    rd_fifo_cnt = 10'd496;
    do_burst("t4 rd at 496", 1, 0, 2, 0, 0, cyc);
    chk("t4 latency", cyc, 2);

    // Clear during a read burst
    wait_start(6, 0, dir, a, cyc);
    chk("t5 grant", dir, 1);
    chk("t5 start addr", a, 32'(exp_addr[1]));
    addr_clr = 1'b1; tick(); addr_clr = 1'b0;
    repeat (2) tick();
    chk("t5 rd_addr held", rd_addr, 32'(exp_addr[1]));
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    rd_mem_en = 1'b0; wr_fifo_cnt = 10'd0;
    chk("t5 rd_addr cleared", rd_addr, 0);
    tick();
    chk("t5 wr_addr cleared", wr_addr, 0);
    exp_addr[0] = 0; exp_addr[1] = 0; last_dir = 1;

    // Reset during write burst
    wr_fifo_cnt = 10'd16; rd_mem_en = 1'b1; rd_fifo_cnt = 10'd0;
    do_burst("t6 w", 0, 0, 1, 0, 0, cyc);
    do_burst("t6 r", 1, 0, 1, 0, 0, cyc);
    wait_start(6, 0, dir, a, cyc);
    chk("t6 grant", dir, 0);
    chk("t6 addr", a, 128);
    rst_n = 1'b0;
    #1;
    chk("t6 rst wr_start", wr_start, 0);
    chk("t6 rst rd_start", rd_start, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst wr_addr", wr_addr, 0);
    chk("t6 rst rd_addr", rd_addr, 0);
    tick();
    rst_n = 1'b1;
    exp_addr[0] = 0; exp_addr[1] = 0; last_dir = 1;
    do_burst("t6 after reset", 0, 0, 1, 0, 0, cyc);
    chk("t6 fresh latency", cyc, 2);

    // Randomized bursts against the model
    for (int i = 0; i < 80; i++) begin
      wr_fifo_cnt = 10'($urandom_range(0, 40));
      rd_fifo_cnt = 10'($urandom_range(480, 512));
      rd_mem_en   = ($urandom_range(0, 3) != 0);
      we = (wr_fifo_cnt >= 16);
      re = rd_mem_en && (rd_fifo_cnt <= 496);
      ed = pick_dir(we, re, last_dir);
      if (ed < 0) begin
        wait_start(10, 0, dir, a, cyc);
        chk("rand idle", dir, -1);
      end else begin
        clr   = ($urandom_range(0, 4) == 0);
        stray = ($urandom_range(0, 3) == 0);
        do_burst("rand", ed, $urandom_range(0, 3), $urandom_range(0, 5), clr, stray, cyc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
